step_ctrl: RTL and testbench
============================

# step_ctrl

Clock-enable generator that sits directly upstream of `my_computer`. It turns a raw pushbutton into debounced single-step pulses, or, when run mode is selected, into a free-running divided step rate. Its `step_en` output qualifies every processor state update (PC, register file, data RAM), so the core runs on the board clock and no longer clocks itself from a key. A `halt` input from the core stops free-running execution.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable samples required before the debounced key level changes (10 ms at 50 MHz); minimum 2.
- `RUN_DIV`, default 25000000: clocks per step in run mode; minimum 2.

Ports:
- `clk`  in  1  board clock; the only clock in the block.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `key_n`  in  1  raw pushbutton, active-low, asynchronous to `clk`.
- `run_sw`  in  1  raw slide switch, asynchronous; 1 = run mode, 0 = manual step mode.
- `halt`  in  1  synchronous to `clk`, from the core; 1 = halt condition reached (e.g. branch-to-self).
- `step_en`  out  1  single-cycle pulse; the core advances exactly one instruction per pulse.
- `key_db`  out  1  debounced key level, active-high (1 = pressed).
- `mode`  out  2  FSM state: 00 MANUAL, 01 RUN, 10 HALTED.
- `step_count`  out  32  number of `step_en` pulses issued since reset.

## Operation
- Synchronizers: `key_n` and `run_sw` each pass through two flops before any use. The synchronized key is inverted to active-high `key_s`.
- Debouncer:
  - A counter resets to 0 whenever `key_s` equals `key_db`.
  - While they differ, it increments each cycle.
  - When it reaches `DEBOUNCE_CYCLES-1` with `key_s` still different, `key_db` takes the value of `key_s` and the counter clears.
- Press detect: `press` = `key_db` & ~`key_db_q`, where `key_db_q` is `key_db` delayed one cycle. Release generates nothing.
- FSM, evaluated in this order each cycle:
  - MANUAL: on `press`, issue `step_en` (registered). If the synchronized `run_sw` is 1, go to RUN and clear the divider. `halt` is ignored, so manual stepping past a halt is allowed.
  - RUN: the divider counts 0..`RUN_DIV-1` and wraps to 0. `step_en` pulses on the wrap cycle. If `halt` is 1 on a wrap cycle, suppress the pulse and go to HALTED. If `run_sw` is 0, go to MANUAL and clear the divider; no pulse that cycle. `press` is ignored.
  - HALTED: no pulses. When `run_sw` is 0, go to MANUAL. Key presses are ignored.
- Simultaneous events:
  - `press` and `run_sw` rising in the same cycle in MANUAL: the step is issued and the state moves to RUN.
  - `halt` and `run_sw` falling on a wrap cycle: `run_sw` wins; go to MANUAL with no pulse.
- `step_count` increments by 1 on every `step_en` cycle and wraps from 0xFFFFFFFF to 0.

## Timing
- All outputs are registered. Reset values: `step_en`=0, `key_db`=0, `mode`=00, `step_count`=0. The divider, debounce counter and synchronizers also reset to 0; synchronized `run_sw` resets to 0.
- Key latency: a clean press edge on `key_n` at cycle 0 gives `key_db`=1 at cycle 2+`DEBOUNCE_CYCLES` and `step_en`=1 at cycle 3+`DEBOUNCE_CYCLES` for exactly one cycle.
- A bounce shorter than `DEBOUNCE_CYCLES` clean cycles produces no level change and no step.
- Run rate: exactly one pulse per `RUN_DIV` clocks. The first pulse comes `RUN_DIV` cycles after entering RUN.
- Reset mid-operation: any pending pulse is dropped and `mode` returns to MANUAL within the same cycle. No `step_en` appears while `reset` is high.
- `halt` is sampled only on wrap cycles in RUN.

## Configuration
- `STEP_CTRL_COUNT_EN` defined: the 32-bit `step_count` register and its incrementer are compiled in, as described above.
- Not defined: `step_count` is tied to 32'd0 and no counter logic is synthesized. All other behaviour is identical.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `RUN_DIV`=5.
- Reset asserted mid-RUN with the divider at 3 -> `mode`=00, `step_en`=0 and `step_count`=0 immediately; no pulse after release until a new press.
- Clean press (`key_n` 1→0, held 20 cycles) at cycle 0 -> `key_db`=1 at cycle 6; single `step_en` at cycle 7; `step_count`=1; no pulse on release.
- Bouncy press (`key_n` toggles every 2 cycles for 10 cycles, then held low) -> exactly one `step_en`, issued 7 cycles after the last bounce.
- `run_sw`=1 for 22 cycles after sync -> `mode`=01; `step_en` pulses spaced exactly 5 cycles apart; `step_count`=4.
- In RUN, `halt`=1 held -> next wrap produces no pulse and `mode`=10. `run_sw`=0 then gives `mode`=00, and a key press again yields exactly one step.
- Compile without `STEP_CTRL_COUNT_EN`, run the run-mode scenario -> identical `step_en` pattern; `step_count` stays 0.

Source files
------------

// File: rtl/step_ctrl.sv
// step_ctrl: clock-enable generator for my_computer. Converts a raw pushbutton
// into debounced single-step pulses. In run mode it instead produces a divided,
// free-running step rate, which stops when the core raises halt.
// Optional build macro: STEP_CTRL_COUNT_EN compiles in the 32-bit step_count
// register. When the macro is undefined, step_count is tied to zero.
`timescale 1ns/1ps
module step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIV         = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_n,
  input  logic        run_sw,
  input  logic        halt,
  output logic        step_en,
  output logic        key_db,
  output logic [1:0]  mode,
  output logic [31:0] step_count
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int DIV_W = $clog2(RUN_DIV);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

  // The key is inverted on entry, so the synchronizer holds the active-high
  // level. Because of this, the reset value 0 means "not pressed" and cannot
  // produce a spurious press when reset is released.
  logic key_p0, key_p1;
  logic run_p0, run_p1;

  logic [DB_W-1:0]  db_cnt;
  logic             key_db_q;
  logic             press;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             step_d;

  // Two-flop synchronizers for the asynchronous key and run switch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_p0 <= 1'b0;
      key_p1 <= 1'b0;
      run_p0 <= 1'b0;
      run_p1 <= 1'b0;
    end else begin
      key_p0 <= ~key_n;
      key_p1 <= key_p0;
      run_p0 <= run_sw;
      run_p1 <= run_p0;
    end
  end

  // Debouncer: the level follows key_s only after DEBOUNCE_CYCLES differing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt   <= '0;
      key_db   <= 1'b0;
      key_db_q <= 1'b0;
    end else begin
      key_db_q <= key_db;
      if (key_p1 == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        key_db <= key_p1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = key_db & ~key_db_q;

  // State, divider and step pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MANUAL;
      div_q   <= '0;
      step_en <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      step_en <= step_d;
    end
  end

  // Next-state logic. In RUN, dropping run_sw takes priority over the
  // halt check on a wrap cycle.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    step_d  = 1'b0;
    case (state_q)
      MANUAL: begin
        step_d = press;
        div_d  = '0;
        if (run_p1) state_d = RUN;
      end
      RUN: begin
        if (!run_p1) begin
          state_d = MANUAL;
          div_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          if (halt) state_d = HALTED;
          else      step_d  = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      HALTED: begin
        div_d = '0;
        if (!run_p1) state_d = MANUAL;
      end
      default: begin
        state_d = MANUAL;
        div_d   = '0;
      end
    endcase
  end

  assign mode = state_q;

`ifdef STEP_CTRL_COUNT_EN
  // Pulse counter, updated on the same edge that raises step_en
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       step_count <= '0;
    else if (step_d) step_count <= step_count + 32'd1;
  end
`else
  assign step_count = 32'd0;
`endif

endmodule

// File: tb/tb_step_ctrl.sv
// Bench for step_ctrl with DEBOUNCE_CYCLES=4 and RUN_DIV=5. It uses directed
// scenarios plus random stimulus, all checked against a behavioural model.
`timescale 1ns/1ps
module tb_step_ctrl;

  localparam int DB  = 4;
  localparam int DIV = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_n = 1'b1;
  logic        run_sw = 1'b0;
  logic        halt = 1'b0;
  logic        step_en;
  logic        key_db;
  logic [1:0]  mode;
  logic [31:0] step_count;
  logic [35:0] dutv;

  int n_cmp = 0;
  int n_bad = 0;

  step_ctrl #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .run_sw(run_sw), .halt(halt),
    .step_en(step_en), .key_db(key_db), .mode(mode), .step_count(step_count)
  );

  always #5 clk = ~clk;

  assign dutv = {step_en, key_db, mode, step_count};

  // Reference model: the key and switch are delayed two samples each. The key
  // level flips after DB consecutive differing samples. The run phase counts
  // elapsed cycles modulo DIV. Modes: 0 manual, 1 run, 2 halted.
  bit          mk1 = 0, mk2 = 0, mr1 = 0, mr2 = 0;
  bit          m_db = 0, m_dbq = 0, m_step = 0;
  int          m_len = 0, m_mode = 0, m_phase = 0;
  logic [31:0] m_cnt = 0;
  bit          t_press, t_step, t_db;
  int          t_mode, t_phase, t_len;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mk1 = 0; mk2 = 0; mr1 = 0; mr2 = 0;
      m_db = 0; m_dbq = 0; m_step = 0;
      m_len = 0; m_mode = 0; m_phase = 0; m_cnt = 0;
    end else begin
      t_press = m_db && !m_dbq;
      t_db = m_db;
      if (mk2 == m_db) t_len = 0;
      else if (m_len + 1 >= DB) begin t_db = mk2; t_len = 0; end
      else t_len = m_len + 1;
      t_step = 0; t_mode = m_mode; t_phase = m_phase;
      if (m_mode == 0) begin
        t_step = t_press;
        if (mr2) begin t_mode = 1; t_phase = 0; end
      end else if (m_mode == 1) begin
        if (!mr2) begin t_mode = 0; t_phase = 0; end
        else begin
          t_phase = (m_phase + 1) % DIV;
          if (t_phase == 0) begin
            if (halt) t_mode = 2;
            else      t_step = 1;
          end
        end
      end else if (!mr2) t_mode = 0;
`ifdef STEP_CTRL_COUNT_EN
      if (t_step) m_cnt = m_cnt + 32'd1;
`endif
      m_step = t_step; m_mode = t_mode; m_phase = t_phase;
      m_dbq = m_db; m_db = t_db; m_len = t_len;
      mk2 = mk1; mk1 = !key_n;
      mr2 = mr1; mr1 = run_sw;
    end
  end

  function automatic logic [35:0] expv();
    return {m_step, m_db, 2'(m_mode), m_cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (dutv !== 36'd0) begin
        n_bad++;
        $display("FAIL reset_state cyc%0d: got %h want 0", c, dutv);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_clean_press();
    logic [31:0] base;
    base = step_count;
    key_n = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      n_cmp++;
      if (dutv !== expv()) begin n_bad++; $display("FAIL press_model cyc%0d: got %h want %h", c, dutv, expv()); end
      n_cmp++;
      if (key_db !== (c >= 6)) begin n_bad++; $display("FAIL press_key_db cyc%0d: got %b want %b", c, key_db, (c >= 6)); end
      n_cmp++;
      if (step_en !== (c == 7)) begin n_bad++; $display("FAIL press_step cyc%0d: got %b want %b", c, step_en, (c == 7)); end
    end
`ifdef STEP_CTRL_COUNT_EN
    n_cmp++;
    if (step_count !== base + 32'd1) begin n_bad++; $display("FAIL press_count: got %0d want %0d", step_count, base + 32'd1); end
`else
    n_cmp++;
    if (step_count !== 32'd0) begin n_bad++; $display("FAIL press_count_off: got %0d want 0", step_count); end
`endif
    key_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_cmp++;
      if (step_en !== 1'b0 || dutv !== expv()) begin n_bad++; $display("FAIL release cyc%0d: got %h want %h", c, dutv, expv()); end
    end
  endtask

  task automatic test_bouncy_press();
    int pulses = 0;
    int pcyc = -1;
    for (int c = 0; c < 30; c++) begin
      key_n = (c < 10 && ((c / 2) % 2) == 1);
      tick();
      n_cmp++;
      if (dutv !== expv()) begin n_bad++; $display("FAIL bounce_model cyc%0d: got %h want %h", c + 1, dutv, expv()); end
      if (step_en) begin pulses++; pcyc = c + 1; end
    end
    n_cmp++;
    if (pulses != 1 || pcyc != 15) begin
      n_bad++; $display("FAIL bounce_step: got %0d pulses at %0d want 1 at 15", pulses, pcyc);
    end
    key_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_cmp++;
      if (dutv !== expv()) begin n_bad++; $display("FAIL bounce_release cyc%0d: got %h want %h", c, dutv, expv()); end
    end
  endtask

  task automatic test_run_mode();
    logic [31:0] base;
    int pulses = 0;
    int last = -1;
    int first = -1;
    int bad_gap = 0;
    base = step_count;
    run_sw = 1'b1;
    for (int c = 0; c < 24; c++) begin
      tick();
      n_cmp++;
      if (dutv !== expv()) begin n_bad++; $display("FAIL run_model cyc%0d: got %h want %h", c + 1, dutv, expv()); end
      if (step_en) begin
        if (last >= 0 && (c + 1 - last) != DIV) bad_gap++;
        if (first < 0) first = c + 1;
        last = c + 1;
        pulses++;
      end
    end
    n_cmp++;
    if (pulses != 4 || first != 8 || bad_gap != 0) begin
      n_bad++; $display("FAIL run_pulses: got %0d first %0d badgap %0d want 4 first 8 badgap 0", pulses, first, bad_gap);
    end
    n_cmp++;
    if (mode !== 2'b01) begin n_bad++; $display("FAIL run_mode: got %b want 01", mode); end
`ifdef STEP_CTRL_COUNT_EN
    n_cmp++;
    if (step_count !== base + 32'd4) begin n_bad++; $display("FAIL run_count: got %0d want %0d", step_count, base + 32'd4); end
`else
    n_cmp++;
    if (step_count !== 32'd0) begin n_bad++; $display("FAIL run_count_off: got %0d want 0", step_count); end
`endif
  endtask

  task automatic test_halt();
    int pulses = 0;
    halt = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (dutv !== expv()) begin n_bad++; $display("FAIL halt_model cyc%0d: got %h want %h", c, dutv, expv()); end
      if (step_en) pulses++;
    end
    n_cmp++;
    if (pulses != 0 || mode !== 2'b10) begin n_bad++; $display("FAIL halt_enter: got %0d pulses mode %b want 0 mode 10", pulses, mode); end
    run_sw = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    n_cmp++;
    if (mode !== 2'b00) begin n_bad++; $display("FAIL halt_exit: got %b want 00", mode); end
    halt = 1'b0;
    key_n = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (c == 12) key_n = 1'b1;
      tick();
      n_cmp++;
      if (dutv !== expv()) begin n_bad++; $display("FAIL halt_press_model cyc%0d: got %h want %h", c, dutv, expv()); end
      if (step_en) pulses++;
    end
    n_cmp++;
    if (pulses != 1) begin n_bad++; $display("FAIL halt_press: got %0d pulses want 1", pulses); end
  endtask

  task automatic test_reset_midrun();
    int pulses = 0;
    run_sw = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    n_cmp++;
    if (mode !== 2'b01) begin n_bad++; $display("FAIL rst_enter_run: got %b want 01", mode); end
    for (int c = 0; c < 3; c++) tick();
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (dutv !== 36'd0) begin n_bad++; $display("FAIL rst_immediate: got %h want 0", dutv); end
    run_sw = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (dutv !== 36'd0) begin n_bad++; $display("FAIL rst_held: got %h want 0", dutv); end
    end
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_cmp++;
      if (dutv !== expv()) begin n_bad++; $display("FAIL rst_after_model cyc%0d: got %h want %h", c, dutv, expv()); end
      if (step_en) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin n_bad++; $display("FAIL rst_after_step: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) key_n = ~key_n;
      if ($urandom_range(0, 59) == 0) run_sw = ~run_sw;
      halt = ($urandom_range(0, 3) == 0);
      tick();
      n_cmp++;
      if (dutv !== expv()) begin n_bad++; $display("FAIL random_model cyc%0d: got %h want %h", c, dutv, expv()); end
    end
    halt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bouncy_press();
    test_run_mode();
    test_halt();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
